// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared instruction ids, access sizes and entry type for the store buffer
package store_buffer_pkg;

   localparam logic [5:0] ID_LB  = 6'd8;
   localparam logic [5:0] ID_LH  = 6'd9;
   localparam logic [5:0] ID_LW  = 6'd10;
   localparam logic [5:0] ID_LBU = 6'd11;
   localparam logic [5:0] ID_LHU = 6'd12;
   localparam logic [5:0] ID_SB  = 6'd13;
   localparam logic [5:0] ID_SH  = 6'd14;
   localparam logic [5:0] ID_SW  = 6'd15;

   typedef enum logic [1:0] {
      SZ_NONE,
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } size_e;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  strb;
   } sb_entry_t;

   function automatic size_e store_size(input logic [5:0] id);
      size_e sz;
      sz = SZ_NONE;
      case (id)
         ID_SB:   sz = SZ_BYTE;
         ID_SH:   sz = SZ_HALF;
         ID_SW:   sz = SZ_WORD;
         default: sz = SZ_NONE;
      endcase
      return sz;
   endfunction

   // Sign/zero extension is the core's job; only the byte footprint matters here.
   function automatic size_e load_size(input logic [5:0] id);
      size_e sz;
      sz = SZ_NONE;
      case (id)
         ID_LB, ID_LBU: sz = SZ_BYTE;
         ID_LH, ID_LHU: sz = SZ_HALF;
         ID_LW:         sz = SZ_WORD;
         default:       sz = SZ_NONE;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/store_buffer_lane_gen.sv
// rtl/store_buffer_lane_gen.sv - maps access size and byte address to word address, lane data and strobes
module sb_lane_gen
   import store_buffer_pkg::*;
(
   input  size_e       size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [29:0] waddr_o,
   output logic [31:0] data_o,
   output logic [3:0]  strb_o,
   output logic        misaligned_o
);

   assign waddr_o = addr_i[31:2];

   always_comb begin
      data_o       = '0;
      strb_o       = '0;
      misaligned_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            data_o = {4{data_i[7:0]}};
            strb_o = 4'b0001 << addr_i[1:0];
         end
         SZ_HALF: begin
            data_o       = {2{data_i[15:0]}};
            strb_o       = addr_i[1] ? 4'b1100 : 4'b0011;
            misaligned_o = addr_i[0];
         end
         SZ_WORD: begin
            data_o       = data_i;
            strb_o       = 4'b1111;
            misaligned_o = |addr_i[1:0];
         end
         default: begin
            data_o       = '0;
            strb_o       = '0;
            misaligned_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - post-commit in-order store FIFO with newest-match load forwarding/stall
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enq_valid_i,
   input  logic [5:0]       enq_instr_id_i,
   input  logic [31:0]      enq_addr_i,
   input  logic [31:0]      enq_data_i,
   output logic             enq_ready_o,
   output logic             mem_wr_valid_o,
   output logic [31:0]      mem_wr_addr_o,
   output logic [31:0]      mem_wr_data_o,
   output logic [3:0]       mem_wr_strb_o,
   input  logic             mem_wr_ready_i,
   input  logic             ld_valid_i,
   input  logic [5:0]       ld_instr_id_i,
   input  logic [31:0]      ld_addr_i,
   output logic             ld_hit_o,
   output logic [31:0]      ld_data_o,
   output logic             ld_stall_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   sb_entry_t          buf_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               misalign_q, misalign_d;
   sb_entry_t          last_q, last_d;

   size_e              enq_size;
   sb_entry_t          enq_entry;
   logic               enq_mis;
   logic               full, empty, enq_fire, deq_fire;
   sb_entry_t          head;

   assign enq_size = store_size(enq_instr_id_i);

   sb_lane_gen u_enq_lane (
      .size_i       (enq_size),
      .addr_i       (enq_addr_i),
      .data_i       (enq_data_i),
      .waddr_o      (enq_entry.waddr),
      .data_o       (enq_entry.data),
      .strb_o       (enq_entry.strb),
      .misaligned_o (enq_mis)
   );

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign enq_fire = enq_valid_i && !full && (enq_size != SZ_NONE) && !enq_mis;
   assign deq_fire = !empty && mem_wr_ready_i;

   // Once drained, the outputs hold the last entry written rather than a stale slot.
   assign head = empty ? last_q : buf_q[rd_ptr_q];

   assign enq_ready_o    = !full;
   assign mem_wr_valid_o = !empty;
   assign mem_wr_addr_o  = {head.waddr, 2'b00};
   assign mem_wr_data_o  = head.data;
   assign mem_wr_strb_o  = head.strb;
   assign misalign_o     = misalign_q;
   assign count_o        = count_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + (enq_fire ? PTR_W'(1) : PTR_W'(0));
      rd_ptr_d   = rd_ptr_q + (deq_fire ? PTR_W'(1) : PTR_W'(0));
      count_d    = count_q;
      case ({enq_fire, deq_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      last_d     = deq_fire ? head : last_q;
      misalign_d = enq_valid_i && !full && (enq_size != SZ_NONE) && enq_mis;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
         last_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
         last_q     <= last_d;
         if (enq_fire) begin
            buf_q[wr_ptr_q] <= enq_entry;
         end
      end
   end

   size_e              ld_size;
   logic [29:0]        ld_waddr;
   logic [3:0]         ld_need;
   logic [31:0]        ld_lane_unused;
   logic               ld_mis_unused;
   logic               ld_active, found;
   sb_entry_t          newest;
   logic [PTR_W-1:0]   idx;

   assign ld_size = load_size(ld_instr_id_i);

   sb_lane_gen u_ld_lane (
      .size_i       (ld_size),
      .addr_i       (ld_addr_i),
      .data_i       (32'd0),
      .waddr_o      (ld_waddr),
      .data_o       (ld_lane_unused),
      .strb_o       (ld_need),
      .misaligned_o (ld_mis_unused)
   );

   assign ld_active = ld_valid_i && (ld_size != SZ_NONE);

   // Walk oldest to newest so the last match seen is the one closest to the tail.
   always_comb begin
      found  = 1'b0;
      newest = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (buf_q[idx].waddr == ld_waddr) &&
             |(buf_q[idx].strb & ld_need)) begin
            found  = 1'b1;
            newest = buf_q[idx];
         end
      end
   end

   assign ld_hit_o   = ld_active && found && ((newest.strb & ld_need) == ld_need);
   assign ld_stall_o = ld_active && found && ((newest.strb & ld_need) != ld_need);
   assign ld_data_o  = ld_hit_o ? newest.data : 32'd0;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enq_valid = 1'b0;
   logic [5:0]  enq_id = '0;
   logic [31:0] enq_addr = '0;
   logic [31:0] enq_data = '0;
   logic        enq_ready;
   logic        mem_wr_valid;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_strb;
   logic        mem_wr_ready = 1'b0;
   logic        ld_valid = 1'b0;
   logic [5:0]  ld_id = '0;
   logic [31:0] ld_addr = '0;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        ld_stall;
   logic        misalign;
   logic [2:0]  count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enq_valid_i    (enq_valid),
      .enq_instr_id_i (enq_id),
      .enq_addr_i     (enq_addr),
      .enq_data_i     (enq_data),
      .enq_ready_o    (enq_ready),
      .mem_wr_valid_o (mem_wr_valid),
      .mem_wr_addr_o  (mem_wr_addr),
      .mem_wr_data_o  (mem_wr_data),
      .mem_wr_strb_o  (mem_wr_strb),
      .mem_wr_ready_i (mem_wr_ready),
      .ld_valid_i     (ld_valid),
      .ld_instr_id_i  (ld_id),
      .ld_addr_i      (ld_addr),
      .ld_hit_o       (ld_hit),
      .ld_data_o      (ld_data),
      .ld_stall_o     (ld_stall),
      .misalign_o     (misalign),
      .count_o        (count)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_exp_t;

   typedef struct packed {
      logic        hit;
      logic        stall;
      logic [31:0] data;
   } ld_exp_t;

   wr_exp_t wr_q[$];
   ld_exp_t ld_q[$];
   wr_exp_t we;
   ld_exp_t le;
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && mem_wr_valid && mem_wr_ready) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     mem_wr_addr, mem_wr_data);
         end else begin
            we = wr_q.pop_front();
            check("mem_wr", 80'({mem_wr_addr, mem_wr_data, mem_wr_strb}), 80'(we));
         end
      end
      if (!rst && ld_valid) begin
         if (ld_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got no expectation expected one queued");
         end else begin
            le = ld_q.pop_front();
            check("ld_lookup", 80'({ld_hit, ld_stall, ld_data}), 80'(le));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [5:0] id, input logic [31:0] a, input logic [31:0] d);
      enq_valid = 1'b1;
      enq_id    = id;
      enq_addr  = a;
      enq_data  = d;
      step();
      enq_valid = 1'b0;
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_q.push_back('{addr: a, data: d, strb: s});
   endtask

   task automatic load(input logic [5:0] id, input logic [31:0] a,
                       input logic h, input logic st, input logic [31:0] d);
      ld_q.push_back('{hit: h, stall: st, data: d});
      ld_valid = 1'b1;
      ld_id    = id;
      ld_addr  = a;
      step();
      ld_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int exp_cycles);
      int n;
      n = 0;
      mem_wr_ready = 1'b1;
      while (count != 0 && n < 20) begin
         step();
         n++;
      end
      mem_wr_ready = 1'b0;
      check(name, 80'(n), 80'(exp_cycles));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stale;
      #12;
      check("rst_count", 80'(count), 80'(0));
      check("rst_outputs", 80'({enq_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
                                ld_hit, ld_stall, ld_data, misalign}),
            80'({1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0}));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // SB lane generation with no bypass into an empty buffer
      enq_valid = 1'b1; enq_id = ID_SB; enq_addr = 32'h1003; enq_data = 32'h0000_00A5;
      expect_wr(32'h1000, 32'hA5A5_A5A5, 4'b1000);
      check("sb_no_bypass", 80'(mem_wr_valid), 80'(0));
      step();
      enq_valid = 1'b0;
      check("sb_visible", 80'({mem_wr_valid, mem_wr_addr, mem_wr_strb}), 80'({1'b1, 32'h1000, 4'b1000}));
      drain("sb_drain", 1);

      // Fill to full, hold a fifth store, then drain in order across the pointer wrap
      store(ID_SW, 32'h100, 32'hA000_0001); expect_wr(32'h100, 32'hA000_0001, 4'hF);
      store(ID_SW, 32'h104, 32'hA000_0002); expect_wr(32'h104, 32'hA000_0002, 4'hF);
      store(ID_SW, 32'h108, 32'hA000_0003); expect_wr(32'h108, 32'hA000_0003, 4'hF);
      store(ID_SW, 32'h10C, 32'hA000_0004); expect_wr(32'h10C, 32'hA000_0004, 4'hF);
      check("full_state", 80'({count, enq_ready}), 80'({3'd4, 1'b0}));
      store(ID_SW, 32'h110, 32'hDEAD_BEEF);
      check("full_held", 80'(count), 80'(4));
      drain("full_drain", 4);

      // Newest matching entry wins
      store(ID_SW, 32'h200, 32'h1111_1111); expect_wr(32'h200, 32'h1111_1111, 4'hF);
      store(ID_SW, 32'h200, 32'h2222_2222); expect_wr(32'h200, 32'h2222_2222, 4'hF);
      load(ID_LW,  32'h200, 1'b1, 1'b0, 32'h2222_2222);
      load(ID_LB,  32'h203, 1'b1, 1'b0, 32'h2222_2222);
      load(ID_LHU, 32'h202, 1'b1, 1'b0, 32'h2222_2222);
      load(ID_LW,  32'h204, 1'b0, 1'b0, 32'h0);
      load(ID_SB,  32'h200, 1'b0, 1'b0, 32'h0);
      drain("fwd_drain", 2);

      // Partial overlap stalls until the entry drains
      store(ID_SB, 32'h301, 32'h0000_007F); expect_wr(32'h300, 32'h7F7F_7F7F, 4'b0010);
      load(ID_LH,  32'h300, 1'b0, 1'b1, 32'h0);
      load(ID_LBU, 32'h301, 1'b1, 1'b0, 32'h7F7F_7F7F);
      load(ID_LB,  32'h300, 1'b0, 1'b0, 32'h0);
      drain("stall_drain", 1);
      load(ID_LH,  32'h300, 1'b0, 1'b0, 32'h0);

      // Misaligned stores are dropped with a one-cycle pulse
      store(ID_SW, 32'h402, 32'h5555_5555);
      check("mis_sw_pulse", 80'({misalign, count}), 80'({1'b1, 3'd0}));
      step();
      check("mis_sw_clear", 80'(misalign), 80'(0));
      store(ID_SH, 32'h401, 32'h0000_1234);
      check("mis_sh_pulse", 80'({misalign, count}), 80'({1'b1, 3'd0}));
      store(ID_SH, 32'h402, 32'h1234_BEEF); expect_wr(32'h400, 32'hBEEF_BEEF, 4'b1100);
      check("sh_aligned", 80'({misalign, count}), 80'({1'b0, 3'd1}));
      drain("sh_drain", 1);

      // Reset while draining discards everything still pending
      store(ID_SW, 32'h500, 32'hC000_0001); expect_wr(32'h500, 32'hC000_0001, 4'hF);
      store(ID_SW, 32'h504, 32'hC000_0002);
      store(ID_SW, 32'h508, 32'hC000_0003);
      mem_wr_ready = 1'b1;
      step();
      check("pre_rst_count", 80'(count), 80'(2));
      rst = 1'b1;
      #1;
      check("rst_mid", 80'({count, mem_wr_valid}), 80'({3'd0, 1'b0}));
      @(posedge clk);
      #1;
      rst = 1'b0;
      stale = 0;
      repeat (6) begin
         step();
         if (mem_wr_valid) stale++;
      end
      mem_wr_ready = 1'b0;
      check("no_stale_writes", 80'(stale), 80'(0));

      check("wr_q_empty", 80'(wr_q.size()), 80'(0));
      check("ld_q_empty", 80'(ld_q.size()), 80'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
